// File: rtl/ram_arb_pkg.sv
// Shared types and RAM command encodings for the two-port RAM arbiter.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ADDR    = 2'd1,
    ST_DATA    = 2'd2,
    ST_RD_WAIT = 2'd3
  } state_e;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  function automatic logic [1:0] addr_cmd(input logic we);
    return we ? CMD_WR_ADDR : CMD_RD_ADDR;
  endfunction

endpackage

// File: rtl/ram_arbiter_rr.sv
// Two-way round-robin grant logic; the pointer records which port was granted last.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);

  logic last1_q, last1_d;

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = last1_q ? 2'b01 : 2'b10;
  end

  always_comb begin
    last1_d = last1_q;
    if (update && (gnt != 2'b00)) last1_d = gnt[1];
  end

  // Reset reads as "port 1 granted last" so port 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last1_q <= 1'b1;
    else        last1_q <= last1_d;
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester arbiter serialising transactions onto a shared 2-beat RAM command bus.
// Optional read timeout enabled by macro RAM_ARB_TIMEOUT_EN (adds the err output).
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int MEM_DEPTH = 8,
  parameter int ADDR_SIZE = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0,
  input  logic                 req1,
  input  logic                 we0,
  input  logic                 we1,
  input  logic [ADDR_SIZE-1:0] addr0,
  input  logic [ADDR_SIZE-1:0] addr1,
  input  logic [ADDR_SIZE-1:0] wdata0,
  input  logic [ADDR_SIZE-1:0] wdata1,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic                 rvalid0,
  output logic                 rvalid1,
  output logic [ADDR_SIZE-1:0] rdata,
  output logic                 busy,
  output logic [ADDR_SIZE+1:0] ram_din,
  output logic                 ram_rx_valid,
  input  logic [ADDR_SIZE-1:0] ram_dout,
  input  logic                 ram_tx_valid
`ifdef RAM_ARB_TIMEOUT_EN
  ,
  output logic                 err
`endif
);

  generate
    if (MEM_DEPTH > (1 << ADDR_SIZE)) begin : g_depth_check
      $error("MEM_DEPTH exceeds the range addressable with ADDR_SIZE bits");
    end
  endgenerate

  state_e                 state_q, state_d;
  logic                   owner_q, owner_d;
  logic                   we_q, we_d;
  logic [ADDR_SIZE-1:0]   addr_q, addr_d;
  logic [ADDR_SIZE-1:0]   wdata_q, wdata_d;
  logic [ADDR_SIZE-1:0]   rdata_q, rdata_d;
  logic [1:0]             rvalid_q, rvalid_d;
  logic [1:0]             arb_gnt;
  logic [1:0]             gnt_v;
`ifdef RAM_ARB_TIMEOUT_EN
  logic [3:0]             cnt_q, cnt_d;
  logic                   err_v;
`endif

  rr_arbiter2 u_rr (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    ({req1, req0}),
    .update (state_q == ST_IDLE),
    .gnt    (arb_gnt)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    rvalid_d     = 2'b00;
    gnt_v        = 2'b00;
    ram_din      = '0;
    ram_rx_valid = 1'b0;
`ifdef RAM_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
    err_v        = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (arb_gnt != 2'b00) begin
          gnt_v   = arb_gnt;
          owner_d = arb_gnt[1];
          we_d    = arb_gnt[1] ? we1    : we0;
          addr_d  = arb_gnt[1] ? addr1  : addr0;
          wdata_d = arb_gnt[1] ? wdata1 : wdata0;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        ram_rx_valid = 1'b1;
        ram_din      = {addr_cmd(we_q), addr_q};
        state_d      = ST_DATA;
      end
      ST_DATA: begin
        ram_rx_valid = 1'b1;
        if (we_q) begin
          ram_din = {CMD_WR_DATA, wdata_q};
          state_d = ST_IDLE;
        end else begin
          ram_din = {CMD_RD_DATA, {ADDR_SIZE{1'b0}}};
          state_d = ST_RD_WAIT;
        end
`ifdef RAM_ARB_TIMEOUT_EN
        cnt_d = 4'd0;
`endif
      end
      ST_RD_WAIT: begin
        if (ram_tx_valid) begin
          rdata_d  = ram_dout;
          rvalid_d = owner_q ? 2'b10 : 2'b01;
          state_d  = ST_IDLE;
        end
`ifdef RAM_ARB_TIMEOUT_EN
        // 16th wait cycle: report the failure now and return zero data.
        else if (cnt_q == 4'hF) begin
          err_v   = 1'b1;
          rdata_d = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 2'b00;
`ifdef RAM_ARB_TIMEOUT_EN
      cnt_q    <= 4'd0;
`endif
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
`ifdef RAM_ARB_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  // Grants are combinational from IDLE, so they are masked while reset is held.
  assign gnt0 = gnt_v[0] & rst_n;
  assign gnt1 = gnt_v[1] & rst_n;
  assign busy = (state_q != ST_IDLE);

`ifdef RAM_ARB_TIMEOUT_EN
  assign err     = err_v;
  assign rvalid0 = rvalid_q[0] | (err_v & ~owner_q);
  assign rvalid1 = rvalid_q[1] | (err_v &  owner_q);
  assign rdata   = err_v ? '0 : rdata_q;
`else
  assign rvalid0 = rvalid_q[0];
  assign rvalid1 = rvalid_q[1];
  assign rdata   = rdata_q;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: stimulus pushes expected events, a negedge monitor pops and compares.
module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [2:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
  logic       gnt0, gnt1, rvalid0, rvalid1, busy, ram_rx_valid;
  logic [2:0] rdata;
  logic [4:0] ram_din;
  logic [2:0] ram_dout = 0;
  logic       ram_tx_valid = 0;
`ifdef RAM_ARB_TIMEOUT_EN
  logic       err;
`endif

  always #5 clk = ~clk;

  ram_arbiter #(.MEM_DEPTH(8), .ADDR_SIZE(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .busy(busy), .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
    .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid)
`ifdef RAM_ARB_TIMEOUT_EN
    , .err(err)
`endif
  );

  localparam int K_GNT = 0, K_RAM = 1, K_RV = 2;
  typedef struct { int kind; logic [7:0] val; } exp_t;
  exp_t sb[$];

  int errors = 0, checks = 0, cyc = 0, last_gnt_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int k, input logic [7:0] v);
    exp_t e;
    e.kind = k; e.val = v;
    sb.push_back(e);
  endtask

  task automatic observe(input int k, input logic [7:0] v);
    exp_t e;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL unexpected_event: got kind %0d val %0h expected nothing (cycle %0d)", k, v, cyc);
    end else begin
      e = sb.pop_front();
      chk("sb_kind", k, e.kind);
      chk("sb_val", v, e.val);
    end
  endtask

  // Monitor: sample mid-cycle, away from the active edge.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (rst_n) begin
      if (!ram_rx_valid) chk("ram_din_idle_zero", ram_din, 0);
      if (rvalid0 || rvalid1) begin
        observe(K_RV, {3'b000, rvalid1, rvalid0, rdata});
        chk("rv_latency", cyc - last_gnt_cyc, 5);
      end
      if (gnt0 || gnt1) begin
        observe(K_GNT, {6'b0, gnt1, gnt0});
        chk("gnt_not_busy", busy, 0);
        last_gnt_cyc = cyc;
      end
      if (ram_rx_valid) begin
        observe(K_RAM, {3'b000, ram_din});
        chk("cmd_busy", busy, 1);
        chk("cmd_latency", cyc - last_gnt_cyc, (ram_din[4:3] == 2'b00 || ram_din[4:3] == 2'b10) ? 1 : 2);
      end
    end
  end

  // RAM model: stores writes, answers reads two cycles after the read-data command.
  logic [2:0] mem [8];
  logic [2:0] cur_addr = 0;
  int         rd_cnt = 0;
  bit         ram_auto = 1;

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 3'b000;
    forever begin
      @(negedge clk);
      if (ram_auto) begin
        ram_tx_valid = 1'b0;
        if (rd_cnt > 0) begin
          rd_cnt--;
          if (rd_cnt == 0) begin
            ram_tx_valid = 1'b1;
            ram_dout     = mem[cur_addr];
          end
        end
      end
      if (rst_n && ram_rx_valid) begin
        case (ram_din[4:3])
          2'b00, 2'b10: cur_addr = ram_din[2:0];
          2'b01:        mem[cur_addr] = ram_din[2:0];
          default:      if (ram_auto) rd_cnt = 2;
        endcase
      end
    end
  end

  task automatic push_txn(input int port, input bit we, input logic [2:0] a,
                          input logic [2:0] d, input logic [2:0] rexp, input bit want_rv);
    logic p1;
    p1 = (port == 1);
    push(K_GNT, {6'b0, p1, ~p1});
    push(K_RAM, {3'b000, (we ? 2'b00 : 2'b10), a});
    push(K_RAM, we ? {3'b000, 2'b01, d} : {3'b000, 2'b11, 3'b000});
    if (!we && want_rv) push(K_RV, {3'b000, p1, ~p1, rexp});
  endtask

  task automatic issue(input int port, input bit we, input logic [2:0] a,
                       input logic [2:0] d, input logic [2:0] rexp, input bit want_rv);
    int n;
    push_txn(port, we, a, d, rexp, want_rv);
    @(posedge clk); #1;
    if (port == 0) begin req0 = 1; we0 = we; addr0 = a; wdata0 = d; end
    else           begin req1 = 1; we1 = we; addr1 = a; wdata1 = d; end
    n = 0;
    do begin @(negedge clk); n++; end
    while (!((port == 0) ? gnt0 : gnt1) && n < 40);
    if (n >= 40) chk("gnt_timeout", 0, 1);
    @(posedge clk); #1;
    req0 = 0; req1 = 0;
  endtask

  // Both ports held high; grants must alternate starting at port 0, 3 cycles apart.
  task automatic contend(input int count);
    int g, n, prev;
    for (int i = 0; i < count; i++)
      push_txn(i % 2, 1'b1, (i % 2 == 0) ? 3'b001 : 3'b010, (i % 2 == 0) ? 3'b011 : 3'b100, 3'b000, 1'b0);
    @(posedge clk); #1;
    req0 = 1; we0 = 1; addr0 = 3'b001; wdata0 = 3'b011;
    req1 = 1; we1 = 1; addr1 = 3'b010; wdata1 = 3'b100;
    g = 0; n = 0; prev = -1;
    while (g < count && n < 80) begin
      @(negedge clk); n++;
      if (gnt0 || gnt1) begin
        if (prev >= 0) chk("contend_gap", n - prev, 3);
        prev = n; g++;
      end
    end
    chk("contend_grants", g, count);
    @(posedge clk); #1;
    req0 = 0; req1 = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin @(negedge clk); n++; end
    chk("drain", sb.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_state", {gnt0, gnt1, rvalid0, rvalid1, rdata, busy, ram_din, ram_rx_valid}, 0);
    @(posedge clk); #1 rst_n = 1;

    issue(0, 1'b1, 3'b110, 3'b101, 3'b000, 1'b0);
    issue(1, 1'b0, 3'b110, 3'b000, 3'b101, 1'b1);
    drain();
    contend(4);
    issue(1, 1'b0, 3'b001, 3'b000, 3'b011, 1'b1);
    issue(0, 1'b0, 3'b010, 3'b000, 3'b100, 1'b1);
    drain();

    // Stray ram_tx_valid while IDLE must not disturb rdata or raise rvalid.
    ram_auto = 0;
    @(negedge clk); ram_dout = 3'b111; ram_tx_valid = 1;
    @(negedge clk); ram_tx_valid = 0;
    chk("idle_tx_rdata", rdata, 3'b100);
    chk("idle_tx_rvalid", {rvalid0, rvalid1}, 0);
    @(negedge clk);
    chk("idle_tx_rvalid2", {rvalid0, rvalid1}, 0);

    // Reset while waiting for read data.
    issue(0, 1'b0, 3'b010, 3'b000, 3'b000, 1'b0);
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("rdwait_busy", busy, 1);
    #1 rst_n = 0; req1 = 1;
    #1 chk("reset_mid_read", {gnt0, gnt1, rvalid0, rvalid1, rdata, busy, ram_din, ram_rx_valid}, 0);
    @(negedge clk); req1 = 0;
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk); ram_dout = 3'b110; ram_tx_valid = 1;
    @(negedge clk); ram_tx_valid = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("late_tx_rvalid", {rvalid0, rvalid1, busy}, 0);
      chk("late_tx_rdata", rdata, 0);
    end
    ram_auto = 1;

    // Pointer back to "port 1 last": port 0 must win the first tie.
    contend(2);
    drain();
    chk("final_queue_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
